// File: rtl/timestamper_capture_ctrl.sv
// timestamper_capture_ctrl
//   Sequences one timestamped capture into the sample buffer. The startBuffer
//   register word is decoded into arm / wait_trig / abort / length fields. A
//   rising edge on arm starts a capture. The capture either begins at once or
//   waits for trig_in. N samples are then written to the buffer RAM at
//   incrementing addresses, and the cycle count at capture start is latched.
//
// Ports
//   user_clk    design clock, all logic on the rising edge
//   user_rst    synchronous active-high reset
//   start_reg   startBuffer word: [0] arm, [1] wait_trig, [2] abort,
//               [31:16] length N (0 or > depth means full depth)
//   trig_in     one-cycle trigger pulse
//   data_in     sample data
//   data_valid  data_in valid this cycle
//   buf_we      buffer write enable (registered)
//   buf_addr    buffer write address (registered)
//   buf_data    buffer write data (registered)
//   busy        waiting for a trigger or capturing
//   done        capture complete, held until arm is cleared
//   trig_time   free-running cycle count latched at capture start
//   status      {state[1:0], 13'b0, missed, wr_count[15:0]}
module timestamper_capture_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              user_clk,
  input  logic              user_rst,
  input  logic [31:0]       start_reg,
  input  logic              trig_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       trig_time,
  output logic [31:0]       status
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // One bit wider than the 16-bit length field so that a full-depth capture
  // of 2^ADDR_W samples (up to ADDR_W = 16) stays representable.
  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

  state_t      state, state_n;
  logic        arm_q;
  logic [31:0] ts_cnt;
  logic [16:0] wr_count;
  logic [16:0] n_eff;
  logic        missed;

  logic        arm, wait_trig, abort, arm_rise;
  logic        do_start, do_write, latch_ts;
  logic        unused_bits;

  assign arm         = start_reg[0];
  assign wait_trig   = start_reg[1];
  assign abort       = start_reg[2];
  assign arm_rise    = arm & ~arm_q;
  assign unused_bits = ^start_reg[15:3];

  function automatic logic [16:0] clamp_len(input logic [15:0] len);
    logic [16:0] len_ext;
    len_ext = {1'b0, len};
    if (len == 16'd0 || len_ext > DEPTH) clamp_len = DEPTH;
    else                                 clamp_len = len_ext;
  endfunction

  always_ff @(posedge user_clk) begin
    if (user_rst) state <= S_IDLE;
    else          state <= state_n;
  end

  // Abort overrides everything, including the write strobe of this cycle.
  always_comb begin
    state_n  = state;
    do_start = 1'b0;
    do_write = 1'b0;
    latch_ts = 1'b0;
    if (abort) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (arm_rise) begin
            do_start = 1'b1;
            if (wait_trig) begin
              state_n = S_WAIT;
            end else begin
              state_n  = S_CAPTURE;
              latch_ts = 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (trig_in) begin
            state_n  = S_CAPTURE;
            latch_ts = 1'b1;
          end else if (!arm) begin
            state_n = S_IDLE;
          end
        end
        S_CAPTURE: begin
          if (data_valid) begin
            do_write = 1'b1;
            if (wr_count == n_eff - 17'd1) state_n = S_DONE;
          end
        end
        S_DONE: begin
          if (!arm) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      arm_q     <= 1'b0;
      ts_cnt    <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      buf_we    <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      trig_time <= 32'd0;
      wr_count  <= 17'd0;
      n_eff     <= 17'd0;
      missed    <= 1'b0;
    end else begin
      arm_q  <= arm;
      ts_cnt <= ts_cnt + 32'd1;
      busy   <= (state_n == S_WAIT) || (state_n == S_CAPTURE);
      done   <= (state_n == S_DONE);
      buf_we <= do_write;
      if (do_write) begin
        buf_addr <= wr_count[ADDR_W-1:0];
        buf_data <= data_in;
      end
      if (latch_ts) trig_time <= ts_cnt;
      if (abort) begin
        wr_count <= 17'd0;
      end else if (do_start) begin
        wr_count <= 17'd0;
        n_eff    <= clamp_len(start_reg[31:16]);
      end else if (do_write) begin
        wr_count <= wr_count + 17'd1;
      end
      // missed is sticky until the next arm; do_start only occurs in IDLE,
      // so it never collides with a trigger seen during CAPTURE.
      if (do_start)                                     missed <= 1'b0;
      else if (!abort && state == S_CAPTURE && trig_in) missed <= 1'b1;
    end
  end

  assign status = {state, 13'b0, missed, wr_count[15:0]};

endmodule
